// File: rtl/gtia_an_decoder.sv
// Receive end of the ANTIC->GTIA AN stream: turns each color-clock code into
// a pixel pair, filters sync codes into hsync/vsync and tracks beam position.
module gtia_an_decoder #(
  parameter int SYNC_FILTER = 2,
  parameter int HPOS_W      = 8,
  parameter int VPOS_W      = 9
) (
  input  logic              Fphi0,
  input  logic              rst,
  input  logic [3:0]        AN,
  input  logic [7:0]        COLBK,
  input  logic [7:0]        COLPF0,
  input  logic [7:0]        COLPF1,
  input  logic [7:0]        COLPF2,
  input  logic [7:0]        COLPF3,
  output logic [7:0]        pixL,
  output logic [7:0]        pixR,
  output logic              hsync,
  output logic              vsync,
  output logic              frameDone,
  output logic [HPOS_W-1:0] hpos,
  output logic [VPOS_W-1:0] vpos,
  output logic [HPOS_W-1:0] lineWidth,
  output logic [VPOS_W-1:0] frameLines,
  output logic [1:0]        state_dbg
);

  localparam int CW = $clog2(SYNC_FILTER + 1);
  localparam logic [CW-1:0] SF_MAX = CW'(SYNC_FILTER);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_HSYNC  = 2'd1,
    ST_VSYNC  = 2'd2
  } state_t;

  state_t          st_q;
  state_t          st_nx;
  logic [3:0]      an_q;
  logic            an_v;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_nx;
  logic [1:0]      cls_q;
  logic            is_sync;
  logic [1:0]      sync_cls;
  logic            sync_rec;
  logic            hs_rec;
  logic            vs_rec;
  logic            hs_bit;
  logic            vs_bit;
  logic            hires;
  logic [7:0]      pf_col;
  logic [7:0]      hi_col;
  logic [7:0]      pix_l_nx;
  logic [7:0]      pix_r_nx;
  logic            hsync_nx;

  assign state_dbg = st_q;

  // Code classes come from an_q[2:0]; bit 3 only selects hi-res for PF codes.
  assign is_sync  = ~an_q[2] & (an_q[1:0] != 2'b00);
  assign sync_cls = an_q[1:0];
  assign hs_bit   = is_sync & an_q[1];
  assign vs_bit   = is_sync & an_q[0];
  assign hires    = an_q[3] & an_q[2];

  always_comb begin
    cnt_nx = '0;
    if (is_sync) begin
      if (cnt_q != '0 && sync_cls == cls_q) begin
        cnt_nx = (cnt_q == SF_MAX) ? SF_MAX : cnt_q + CW'(1);
      end else begin
        cnt_nx = CW'(1);
      end
    end
  end

  assign sync_rec = is_sync && (cnt_nx == SF_MAX);
  assign hs_rec   = sync_rec && (sync_cls == 2'b10);
  assign vs_rec   = sync_rec && sync_cls[0];

  always_comb begin
    st_nx = st_q;
    case (st_q)
      ST_ACTIVE: begin
        if (vs_rec)      st_nx = ST_VSYNC;
        else if (hs_rec) st_nx = ST_HSYNC;
      end
      ST_HSYNC: begin
        if (vs_rec)       st_nx = ST_VSYNC;
        else if (!hs_bit) st_nx = ST_ACTIVE;
      end
      ST_VSYNC: begin
        if (!vs_bit) st_nx = ST_ACTIVE;
      end
      default: st_nx = ST_ACTIVE;
    endcase
  end

  // In VSYNC, hsync follows the live class so HS+VS shows both strobes.
  assign hsync_nx = (st_nx == ST_HSYNC) ||
                    (st_nx == ST_VSYNC && is_sync && sync_cls == 2'b11);

  always_comb begin
    pf_col = COLPF0;
    case (an_q[1:0])
      2'd0: pf_col = COLPF0;
      2'd1: pf_col = COLPF1;
      2'd2: pf_col = COLPF2;
      2'd3: pf_col = COLPF3;
      default: pf_col = COLPF0;
    endcase
  end

  assign hi_col = {COLPF2[7:4], COLPF1[3:0]};

  always_comb begin
    pix_l_nx = COLBK;
    pix_r_nx = COLBK;
    if (hires) begin
      pix_l_nx = an_q[1] ? hi_col : COLPF2;
      pix_r_nx = an_q[0] ? hi_col : COLPF2;
    end else if (an_q[2]) begin
      pix_l_nx = pf_col;
      pix_r_nx = pf_col;
    end else if (sync_rec) begin
      pix_l_nx = 8'h00;
      pix_r_nx = 8'h00;
    end
  end

  // an_v keeps stage 2 idle until an_q holds a real post-reset sample.
  always_ff @(posedge Fphi0) begin
    if (rst) begin
      an_q       <= '0;
      an_v       <= 1'b0;
      cnt_q      <= '0;
      cls_q      <= '0;
      st_q       <= ST_ACTIVE;
      pixL       <= '0;
      pixR       <= '0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      frameDone  <= 1'b0;
      hpos       <= '0;
      vpos       <= '0;
      lineWidth  <= '0;
      frameLines <= '0;
    end else begin
      an_q      <= AN;
      an_v      <= 1'b1;
      frameDone <= 1'b0;
      if (an_v) begin
        cnt_q <= cnt_nx;
        if (is_sync) cls_q <= sync_cls;
        st_q  <= st_nx;
        pixL  <= pix_l_nx;
        pixR  <= pix_r_nx;
        hsync <= hsync_nx;
        vsync <= (st_nx == ST_VSYNC);
        if (st_q != ST_VSYNC && st_nx == ST_VSYNC) begin
          frameLines <= vpos;
          vpos       <= '0;
          hpos       <= '0;
          frameDone  <= 1'b1;
        end else if (st_q == ST_ACTIVE && st_nx == ST_HSYNC) begin
          lineWidth <= hpos;
          hpos      <= '0;
          if (vpos != '1) vpos <= vpos + VPOS_W'(1);
        end else if (st_q == ST_ACTIVE && hpos != '1) begin
          hpos <= hpos + HPOS_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gtia_an_decoder.sv
// Directed bench for gtia_an_decoder: decode, hi-res, sync filtering and
// line/frame bookkeeping with hand-computed expectations.
module tb_gtia_an_decoder;

  logic       Fphi0;
  logic       rst;
  logic [3:0] AN;
  logic [7:0] COLBK, COLPF0, COLPF1, COLPF2, COLPF3;
  logic [7:0] pixL, pixR;
  logic       hsync, vsync, frameDone;
  logic [7:0] hpos, lineWidth;
  logic [8:0] vpos, frameLines;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  gtia_an_decoder #(.SYNC_FILTER(2), .HPOS_W(8), .VPOS_W(9)) dut (
    .Fphi0(Fphi0), .rst(rst), .AN(AN),
    .COLBK(COLBK), .COLPF0(COLPF0), .COLPF1(COLPF1), .COLPF2(COLPF2), .COLPF3(COLPF3),
    .pixL(pixL), .pixR(pixR), .hsync(hsync), .vsync(vsync), .frameDone(frameDone),
    .hpos(hpos), .vpos(vpos), .lineWidth(lineWidth), .frameLines(frameLines),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial Fphi0 = 1'b0;
  always #5 Fphi0 = ~Fphi0;

  task automatic tick();
    @(posedge Fphi0);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    AN  = 4'h4;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // driver + scoreboard for the pixel pipeline: each pushed code shows up two
  // edges after it is driven.
  task automatic push_an(input logic [3:0] code, input logic [15:0] exp_pix);
    logic [15:0] e;
    AN = code;
    exp_q.push_back(exp_pix);
    tick();
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      check("pix", {pixL, pixR}, e);
    end
  endtask

  task automatic drain();
    logic [15:0] e;
    AN = 4'h4;
    tick();
    e = exp_q.pop_front();
    check("pix_drain", {pixL, pixR}, e);
  endtask

  task automatic line(input int n_active, input int n_sync);
    AN = 4'h4;
    repeat (n_active) tick();
    AN = 4'h2;
    repeat (n_sync) tick();
  endtask

  initial begin
    COLBK = 8'h00; COLPF0 = 8'h3A; COLPF1 = 8'h00; COLPF2 = 8'h00; COLPF3 = 8'h00;

    // reset behaviour
    do_reset();
    check("rst_pixL", pixL, 8'h00);
    check("rst_hsync", hsync, 1'b0);
    check("rst_vsync", vsync, 1'b0);
    check("rst_hpos", hpos, 8'd0);
    check("rst_state", state_dbg, 2'd0);
    tick();
    check("e1_pixL", pixL, 8'h00);
    check("e1_hpos", hpos, 8'd0);
    tick();
    check("e2_pixL", pixL, 8'h3A);
    check("e2_pixR", pixR, 8'h3A);
    check("e2_hpos", hpos, 8'd1);
    tick();
    check("e3_hpos", hpos, 8'd2);
    tick();
    check("e4_hpos", hpos, 8'd3);

    // color decode
    COLBK = 8'h10; COLPF0 = 8'h24; COLPF1 = 8'h46; COLPF2 = 8'h88; COLPF3 = 8'hCA;
    push_an(4'h0, 16'h1010);
    push_an(4'h4, 16'h2424);
    push_an(4'h5, 16'h4646);
    push_an(4'h6, 16'h8888);
    push_an(4'h7, 16'hCACA);
    drain();

    // hi-res
    COLPF2 = 8'h94; COLPF1 = 8'h0E;
    push_an(4'hE, 16'h9E94);
    push_an(4'hD, 16'h949E);
    push_an(4'hF, 16'h9E9E);
    push_an(4'hC, 16'h9494);
    drain();

    // line timing
    COLBK = 8'h10; COLPF0 = 8'h3A;
    do_reset();
    repeat (200) tick();
    AN = 4'h2;
    tick();
    tick();
    check("hs_early", hsync, 1'b0);
    check("glitchpix_early", pixL, 8'h10);
    tick();
    check("hs_rise", hsync, 1'b1);
    check("line_width", lineWidth, 8'd201);
    check("line_vpos", vpos, 9'd1);
    check("line_hpos", hpos, 8'd0);
    check("sync_pix", pixL, 8'h00);
    check("hs_state", state_dbg, 2'd1);
    repeat (2) tick();
    AN = 4'h4;
    tick();
    check("hs_hold", hsync, 1'b1);
    tick();
    check("hs_fall", hsync, 1'b0);
    check("hs_exit_hpos", hpos, 8'd0);
    tick();
    check("resume_hpos", hpos, 8'd1);

    // frame
    line(20, 3);
    check("l2_width", lineWidth, 8'd23);
    check("l2_vpos", vpos, 9'd2);
    line(30, 3);
    check("l3_width", lineWidth, 8'd30);
    check("l3_vpos", vpos, 9'd3);
    AN = 4'h4;
    repeat (5) tick();
    AN = 4'h1;
    tick();
    check("vs_e1", vsync, 1'b0);
    tick();
    check("vs_e2", vsync, 1'b0);
    check("fd_e2", frameDone, 1'b0);
    tick();
    check("vs_rise", vsync, 1'b1);
    check("fd_pulse", frameDone, 1'b1);
    check("frame_lines", frameLines, 9'd3);
    check("frame_vpos", vpos, 9'd0);
    check("frame_hpos", hpos, 8'd0);
    check("vs_hsync", hsync, 1'b0);
    check("vs_state", state_dbg, 2'd2);
    tick();
    check("fd_drop", frameDone, 1'b0);
    check("vs_hold", vsync, 1'b1);

    // reset in the middle of VSYNC
    rst = 1'b1;
    tick();
    check("midrst_vsync", vsync, 1'b0);
    check("midrst_fd", frameDone, 1'b0);
    check("midrst_state", state_dbg, 2'd0);
    check("midrst_flines", frameLines, 9'd0);
    rst = 1'b0;

    // single-cycle HS glitch
    do_reset();
    repeat (10) tick();
    AN = 4'h2;
    tick();
    AN = 4'h4;
    tick();
    check("glitch_pix", pixL, 8'h10);
    check("glitch_hsync", hsync, 1'b0);
    check("glitch_hpos", hpos, 8'd11);
    tick();
    check("glitch_after", pixL, 8'h3A);
    check("glitch_hpos2", hpos, 8'd12);
    check("glitch_state", state_dbg, 2'd0);

    // hpos saturation
    do_reset();
    repeat (300) tick();
    check("hpos_sat", hpos, 8'd255);
    AN = 4'h2;
    repeat (3) tick();
    check("sat_width", lineWidth, 8'd255);

    // HS+VS then VS only
    do_reset();
    repeat (3) tick();
    AN = 4'h3;
    tick();
    tick();
    check("hv_early", vsync, 1'b0);
    tick();
    check("hv_vsync", vsync, 1'b1);
    check("hv_hsync", hsync, 1'b1);
    check("hv_fd", frameDone, 1'b1);
    AN = 4'h1;
    tick();
    check("hv_hold_hs", hsync, 1'b1);
    tick();
    check("v_only_hs", hsync, 1'b0);
    check("v_only_vs", vsync, 1'b1);
    check("v_only_fd", frameDone, 1'b0);
    check("v_only_pix", pixL, 8'h10);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gtia_an_decoder.md
Name: gtia_an_decoder

Overview:
- Receive end of the ANTIC→GTIA AN[3:0] playfield/sync stream: decodes each color-clock AN code into pixel color from the playfield/background color registers, recovers horizontal/vertical sync, and tracks beam position.
- Sits directly downstream of ANTIC's AN output.
- Drives the video output stage and provides position and line/frame-length status for debug.

Parameters:
- SYNC_FILTER, 2: consecutive cycles a sync code must persist before sync is recognized (≥1).
- HPOS_W, 8: width of horizontal position counter.
- VPOS_W, 9: width of vertical line counter.

Ports:
- Fphi0  in  1  color clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- AN  in  4  AN code from ANTIC, sampled every Fphi0 rising edge.
- COLBK  in  8  background color register (hue[7:4], luma[3:0]).
- COLPF0..COLPF3  in  8 each  playfield color registers.
- pixL  out  8  left half-clock pixel color.
- pixR  out  8  right half-clock pixel color.
- hsync  out  1  recognized horizontal sync.
- vsync  out  1  recognized vertical sync.
- frameDone  out  1  one-cycle pulse on VSYNC entry.
- hpos  out  HPOS_W  color clocks since last line start.
- vpos  out  VPOS_W  lines since last frame start.
- lineWidth  out  HPOS_W  hpos value captured at last HSYNC entry.
- frameLines  out  VPOS_W  vpos value captured at last VSYNC entry.

Behaviour:
- Reset: every output and internal register is 0; state is ACTIVE; filter counter is 0. Reset mid-line or mid-sync aborts immediately, with no frameDone pulse.
- Stage 1: an_q <= AN every edge.
- Stage 2: decode an_q into pixL/pixR, registered.
- Latency: AN sampled at edge k appears on pixL/pixR after edge k+1.
- Color registers are read combinationally at stage 2, so a change applies from the next decoded pixel.
- AN code classes, using an_q[2:0]:
  - 000: BK.
  - 001: VS.
  - 010: HS.
  - 011: HS+VS.
  - 1xx: playfield PF(an_q[1:0]).
- Color decode (an_q[3]=0, or an_q[3]=1 with an_q[2]=0): pixL = pixR =
  - COLBK for BK, or for any sync code not yet recognized.
  - 8'h00 for a recognized sync.
  - COLPFn for PFn.
- Hi-res decode (an_q[3]=1 and an_q[2]=1):
  - pixL uses bit an_q[1]; pixR uses bit an_q[0].
  - Bit=1 → {COLPF2[7:4], COLPF1[3:0]}.
  - Bit=0 → COLPF2.
- Sync filter:
  - Counter increments while an_q holds the same sync class (VS, HS or HS+VS); resets to 1 on a class change; clears on a non-sync code. It saturates at SYNC_FILTER.
  - Recognition occurs at the edge where the counter reaches SYNC_FILTER.
  - With AN held at a sync code from edge k, hsync/vsync go high after edge k+SYNC_FILTER.
- States:
  - ACTIVE: hpos increments each cycle, saturating at all-ones. On HS recognized → HSYNC. On VS or HS+VS recognized → VSYNC (VS has priority).
  - HSYNC: hsync=1. Any code without the HS bit → ACTIVE. VS or HS+VS recognized → VSYNC.
  - VSYNC: vsync=1; hsync=1 only while the class is HS+VS. First code without the VS bit → ACTIVE.
- HSYNC entry, same edge:
  - lineWidth <= hpos; hpos <= 0.
  - vpos <= vpos+1, saturating at all-ones.
- VSYNC entry, same edge:
  - frameLines <= vpos; vpos <= 0; hpos <= 0; frameDone = 1 for one cycle.
  - Entry from HSYNC also pulses frameDone.
- hpos does not count in HSYNC or VSYNC. It holds 0 through sync and resumes from 1 on the first ACTIVE cycle.
- Glitch of fewer than SYNC_FILTER cycles: no state change; those pixels output COLBK; hpos keeps counting.

Test Plan:
- Reset: assert rst with AN=4'h4 and COLPF0=8'h3A, then release → all outputs stay 0 until edge 2 after release; then pixL=pixR=8'h3A and hpos increments 1,2,3.
- Color decode: COLBK=8'h10, PF0..3=8'h24,8'h46,8'h88,8'hCA; AN sequence 0,4,5,6,7 → pix sequence 10,24,46,88,CA at 2-cycle latency.
- Hi-res: COLPF2=8'h94, COLPF1=8'h0E; AN=4'hE (bits 10) → pixL=8'h9E, pixR=8'h94; AN=4'hD → pixL=8'h94, pixR=8'h9E.
- Line timing: 200 cycles AN=4 then 5 cycles AN=2 with SYNC_FILTER=2 → hsync rises 2 edges after the first 2 is sampled; lineWidth=201 (the first filter cycle still counts); vpos=1; hpos=0; hsync falls on the return to AN=4.
- Frame: 3 lines, then AN=1 for 4 cycles → vsync=1, frameDone a single 1-cycle pulse, frameLines=3, vpos=0.
- Glitch and mid-sync reset: a single-cycle AN=2 → no hsync, pix=COLBK, hpos continues; rst during VSYNC → vsync=0 and frameDone=0 next edge, state ACTIVE.
